mdu_div_sched: RTL and testbench

Sequencing controller that owns the shared multi-cycle divider on behalf of the MDU. It accepts DIV/DIVU from the execute stage, drives the divider start/operand handshake, and writes the quotient and remainder back into HI/LO. It also holds the pipeline only when an instruction actually depends on HI/LO while a divide is in flight.

---
 rtl/mdu_div_sched_if.sv | 46 ++++
 rtl/mdu_div_sched.sv | 159 +++++++++++++++
 tb/tb_mdu_div_sched.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_div_sched_if.sv
`default_nettype none
//==============================================================================
// Module   : mdu_div_sched_if
// Desc     : Execute-stage, divider and HI/LO write bundle for mdu_div_sched.
// Revision : 1.0 - initial release
//==============================================================================
interface mdu_div_sched_if #(
    parameter int DATA_WIDTH = 32
);
    // execute-stage side
    logic                  op_valid_i;
    logic [3:0]            op_i;
    logic [DATA_WIDTH-1:0] a_i;
    logic [DATA_WIDTH-1:0] b_i;
    logic                  cancel_i;
    logic                  stall_o;
    logic                  busy_o;
    // divider side
    logic                  div_start_o;
    logic                  div_signed_o;
    logic [DATA_WIDTH-1:0] div_dividend_o;
    logic [DATA_WIDTH-1:0] div_divisor_o;
    logic                  div_ready_i;
    logic [DATA_WIDTH-1:0] div_quotient_i;
    logic [DATA_WIDTH-1:0] div_remainder_i;
    // HI/LO write side
    logic                  hilo_wr_o;
    logic [DATA_WIDTH-1:0] hi_o;
    logic [DATA_WIDTH-1:0] lo_o;
    logic                  div_zero_o;

    modport master (
        input  op_valid_i, op_i, a_i, b_i, cancel_i,
               div_ready_i, div_quotient_i, div_remainder_i,
        output stall_o, busy_o, div_start_o, div_signed_o,
               div_dividend_o, div_divisor_o, hilo_wr_o, hi_o, lo_o, div_zero_o
    );

    modport slave (
        output op_valid_i, op_i, a_i, b_i, cancel_i,
               div_ready_i, div_quotient_i, div_remainder_i,
        input  stall_o, busy_o, div_start_o, div_signed_o,
               div_dividend_o, div_divisor_o, hilo_wr_o, hi_o, lo_o, div_zero_o
    );
endinterface
`default_nettype wire

// File: rtl/mdu_div_sched.sv
`default_nettype none
//==============================================================================
// Module   : mdu_div_sched
// Desc     : Owns the shared multi-cycle divider for DIV/DIVU and writes HI/LO.
//            MDU_DIV_NONBLOCK_EN: stall only HI/LO-dependent ops while busy.
// Revision : 1.0 - initial release
//==============================================================================
module mdu_div_sched #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic       clk_i,
    input  wire logic       rst_n_i,
    mdu_div_sched_if.master bus
);
    // MDU_OP_* encodings shared with the execute stage
    localparam logic [3:0] c_OP_MULT  = 4'h1;
    localparam logic [3:0] c_OP_MULTU = 4'h2;
    localparam logic [3:0] c_OP_DIV   = 4'h3;
    localparam logic [3:0] c_OP_DIVU  = 4'h4;
    localparam logic [3:0] c_OP_MFHI  = 4'h5;
    localparam logic [3:0] c_OP_MFLO  = 4'h6;
    localparam logic [3:0] c_OP_MTHI  = 4'h7;
    localparam logic [3:0] c_OP_MTLO  = 4'h8;
    localparam logic [3:0] c_OP_MUL   = 4'h9;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_WRITE = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_kill;
    logic                  w_kill_nxt;
    logic                  w_is_div;
    logic                  w_is_hilo;
    logic                  w_accept;
    logic                  w_zero;
    logic                  w_capture;
    logic                  w_stall;

    logic                  r_busy;
    logic                  r_start;
    logic                  r_wr;
    logic                  r_zero;
    logic                  r_signed;
    logic [DATA_WIDTH-1:0] r_dividend;
    logic [DATA_WIDTH-1:0] r_divisor;
    logic [DATA_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_lo;

    always_comb begin
        w_is_div  = (bus.op_i == c_OP_DIV) || (bus.op_i == c_OP_DIVU);
        w_is_hilo = 1'b0;
        case (bus.op_i)
            c_OP_MFHI, c_OP_MFLO, c_OP_MTHI, c_OP_MTLO,
            c_OP_MULT, c_OP_MULTU, c_OP_MUL, c_OP_DIV, c_OP_DIVU: w_is_hilo = 1'b1;
            default:                                             w_is_hilo = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= c_ST_IDLE;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        w_accept    = 1'b0;
        w_zero      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_kill_nxt = 1'b0;
                if (bus.op_valid_i && w_is_div) begin
                    if (bus.b_i != '0) begin
                        w_accept    = 1'b1;
                        w_state_nxt = c_ST_START;
                    end else begin
                        w_zero = 1'b1;
                    end
                end
            end
            c_ST_START: begin
                if (bus.cancel_i) w_kill_nxt = 1'b1;
                w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (bus.cancel_i) w_kill_nxt = 1'b1;
                // a killed divide still drains the divider but never writes HI/LO
                if (bus.div_ready_i) begin
                    w_kill_nxt = 1'b0;
                    if (r_kill || bus.cancel_i) begin
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = c_ST_WRITE;
                    end
                end
            end
            c_ST_WRITE: w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

`ifdef MDU_DIV_NONBLOCK_EN
    assign w_stall = (r_state != c_ST_IDLE) && bus.op_valid_i && w_is_hilo;
`else
    // WRITE releases the held DIV so it retires exactly once
    assign w_stall = w_accept || (r_state == c_ST_START) || (r_state == c_ST_WAIT);
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_busy     <= 1'b0;
            r_start    <= 1'b0;
            r_wr       <= 1'b0;
            r_zero     <= 1'b0;
            r_signed   <= 1'b0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_busy  <= (w_state_nxt != c_ST_IDLE);
            r_start <= (w_state_nxt == c_ST_START);
            r_wr    <= (w_state_nxt == c_ST_WRITE);
            r_zero  <= w_zero;
            if (w_accept) begin
                r_dividend <= bus.a_i;
                r_divisor  <= bus.b_i;
                r_signed   <= (bus.op_i == c_OP_DIV);
            end
            if (w_capture) begin
                r_hi <= bus.div_remainder_i;
                r_lo <= bus.div_quotient_i;
            end
        end
    end

    assign bus.stall_o        = w_stall && rst_n_i;
    assign bus.busy_o         = r_busy;
    assign bus.div_start_o    = r_start;
    assign bus.div_signed_o   = r_signed;
    assign bus.div_dividend_o = r_dividend;
    assign bus.div_divisor_o  = r_divisor;
    assign bus.hilo_wr_o      = r_wr;
    assign bus.hi_o           = r_hi;
    assign bus.lo_o           = r_lo;
    assign bus.div_zero_o     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_mdu_div_sched.sv
`default_nettype none
//==============================================================================
// Module   : tb_mdu_div_sched
// Desc     : Randomized bench for mdu_div_sched against a timeline reference.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
module tb_mdu_div_sched;
    localparam int DATA_WIDTH = 32;

    localparam logic [3:0] c_OP_NONE  = 4'h0;
    localparam logic [3:0] c_OP_MULT  = 4'h1;
    localparam logic [3:0] c_OP_MULTU = 4'h2;
    localparam logic [3:0] c_OP_DIV   = 4'h3;
    localparam logic [3:0] c_OP_DIVU  = 4'h4;
    localparam logic [3:0] c_OP_MFHI  = 4'h5;
    localparam logic [3:0] c_OP_MFLO  = 4'h6;
    localparam logic [3:0] c_OP_MTHI  = 4'h7;
    localparam logic [3:0] c_OP_MTLO  = 4'h8;
    localparam logic [3:0] c_OP_MUL   = 4'h9;
    localparam logic [3:0] c_OP_ADD   = 4'hA;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_checks;
    int          n_fail;
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic        last_sgn;

    mdu_div_sched_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();
    mdu_div_sched #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit is_hilo(input logic [3:0] op);
        return op inside {c_OP_MFHI, c_OP_MFLO, c_OP_MTHI, c_OP_MTLO,
                          c_OP_MULT, c_OP_MULTU, c_OP_MUL, c_OP_DIV, c_OP_DIVU};
    endfunction

    // MIPS divide semantics: truncate toward zero, remainder takes dividend sign
    function automatic void div_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'd0; r = 32'd0;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic [3:0] rand_non_div();
        logic [3:0] op;
        op = 4'($urandom_range(0, 13));
        if (op >= c_OP_DIV) op = op + 4'd2;
        return op;
    endfunction

    task automatic idle_inputs();
        bus.op_valid_i      = 1'b0;
        bus.op_i            = c_OP_NONE;
        bus.a_i             = '0;
        bus.b_i             = '0;
        bus.cancel_i        = 1'b0;
        bus.div_ready_i     = 1'b0;
        bus.div_quotient_i  = '0;
        bus.div_remainder_i = '0;
    endtask

    // Timeline of one issue at cycle 0: start at 1, ready at 1+lat, write at 2+lat.
    // cc = cycle carrying cancel_i (-1 none); pat 1 = ADD then MFLO stream.
    task automatic run_div(input logic [3:0] dop, input logic [31:0] a, input logic [31:0] b,
                           input int lat, input int cc, input int pat);
        int          r_cyc;
        int          e_cyc;
        bit          nz, kill, stale, busy_exp, wr_exp, stall_exp, cur_valid;
        logic [3:0]  cur_op;
        logic [31:0] eq, er, dq, dr;
        nz    = (b != 32'd0);
        r_cyc = 1 + lat;
        kill  = nz && cc >= 1 && cc <= r_cyc;
        e_cyc = !nz ? 0 : (kill ? r_cyc : r_cyc + 1);
        stale = ($urandom_range(0, 1) == 1);
        div_ref(dop == c_OP_DIV, a, b, eq, er);
        for (int c = 0; c <= e_cyc + 2; c++) begin
            if (c == 0) begin
                cur_valid = 1'b1;
                cur_op    = dop;
                bus.a_i   = a;
                bus.b_i   = b;
            end else begin
                if (pat == 1) begin
                    cur_valid = 1'b1;
                    cur_op    = (c == 1) ? c_OP_ADD : c_OP_MFLO;
                end else begin
                    cur_valid = ($urandom_range(0, 1) == 1);
                    cur_op    = (c <= e_cyc) ? 4'($urandom_range(0, 15)) : rand_non_div();
                end
                bus.a_i = $urandom;
                bus.b_i = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            end
            bus.op_valid_i  = cur_valid;
            bus.op_i        = cur_op;
            bus.cancel_i    = (c == cc);
            bus.div_ready_i = nz && ((c >= r_cyc) || (stale && c == 1));
            if (nz && c >= r_cyc) begin
                div_ref(bus.div_signed_o, bus.div_dividend_o, bus.div_divisor_o, dq, dr);
                bus.div_quotient_i  = dq;
                bus.div_remainder_i = dr;
            end else begin
                bus.div_quotient_i  = $urandom;
                bus.div_remainder_i = $urandom;
            end

            @(negedge clk);
            busy_exp = nz && c >= 1 && c <= e_cyc;
            wr_exp   = nz && !kill && c == r_cyc + 1;
`ifdef MDU_DIV_NONBLOCK_EN
            stall_exp = busy_exp && cur_valid && is_hilo(cur_op);
`else
            stall_exp = nz && c <= r_cyc;
`endif
            check_eq($sformatf("busy c%0d", c),  32'(bus.busy_o),      32'(busy_exp));
            check_eq($sformatf("start c%0d", c), 32'(bus.div_start_o), 32'(nz && c == 1));
            check_eq($sformatf("hilo_wr c%0d", c), 32'(bus.hilo_wr_o), 32'(wr_exp));
            check_eq($sformatf("div_zero c%0d", c), 32'(bus.div_zero_o), 32'(!nz && c == 1));
            check_eq($sformatf("stall c%0d op%0h", c, cur_op), 32'(bus.stall_o), 32'(stall_exp));
            if (wr_exp) begin
                check_eq("hi", bus.hi_o, er);
                check_eq("lo", bus.lo_o, eq);
            end
            check_eq($sformatf("dividend c%0d", c), bus.div_dividend_o, last_a);
            check_eq($sformatf("divisor c%0d", c),  bus.div_divisor_o,  last_b);
            check_eq($sformatf("signed c%0d", c),   32'(bus.div_signed_o), 32'(last_sgn));
            if (c == 0 && nz) begin
                last_a   = a;
                last_b   = b;
                last_sgn = (dop == c_OP_DIV);
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " busy"},     32'(bus.busy_o),      32'd0);
        check_eq({tag, " start"},    32'(bus.div_start_o), 32'd0);
        check_eq({tag, " hilo_wr"},  32'(bus.hilo_wr_o),   32'd0);
        check_eq({tag, " div_zero"}, 32'(bus.div_zero_o),  32'd0);
        check_eq({tag, " stall"},    32'(bus.stall_o),     32'd0);
        check_eq({tag, " signed"},   32'(bus.div_signed_o), 32'd0);
        check_eq({tag, " hi"},       bus.hi_o,             32'd0);
        check_eq({tag, " lo"},       bus.lo_o,             32'd0);
        check_eq({tag, " dividend"}, bus.div_dividend_o,   32'd0);
        check_eq({tag, " divisor"},  bus.div_divisor_o,    32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_a   = 32'd0;
        last_b   = 32'd0;
        last_sgn = 1'b0;
        rst_n    = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        run_div(c_OP_DIVU, 32'd100, 32'd7, 4, -1, 0);
        run_div(c_OP_DIV, 32'hFFFF_FFF9, 32'd2, 3, -1, 0);
        run_div(c_OP_DIV, 32'd123, 32'd0, 1, -1, 0);
        run_div(c_OP_DIV, 32'd1000, 32'd3, 10, -1, 1);
        run_div(c_OP_DIVU, 32'd77, 32'd5, 6, 4, 0);   // cancel in WAIT
        run_div(c_OP_DIVU, 32'd55, 32'd6, 3, 1, 0);   // cancel in START
        run_div(c_OP_DIVU, 32'd55, 32'd6, 3, 5, 0);   // cancel in WRITE: ignored
        run_div(c_OP_DIV, 32'd40, 32'd9, 2, 0, 0);    // cancel in IDLE: ignored
        run_div(c_OP_DIVU, 32'd1, 32'd1, 1, -1, 0);

        // abandon a divide in WAIT with an asynchronous reset
        bus.op_valid_i = 1'b1;
        bus.op_i       = c_OP_DIVU;
        bus.a_i        = 32'd50;
        bus.b_i        = 32'd5;
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_eq("pre-reset busy", 32'(bus.busy_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        last_a   = 32'd0;
        last_b   = 32'd0;
        last_sgn = 1'b0;
        run_div(c_OP_DIVU, 32'd9, 32'd3, 5, -1, 0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  dop;
            logic [31:0] a;
            logic [31:0] b;
            int          lat;
            int          cc;
            dop = ($urandom_range(0, 1) == 1) ? c_OP_DIV : c_OP_DIVU;
            a   = $urandom;
            if ($urandom_range(0, 7) == 0)      b = 32'd0;
            else if ($urandom_range(0, 1) == 1) b = $urandom;
            else                                b = 32'($urandom_range(1, 300));
            if (dop == c_OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            lat = $urandom_range(1, 12);
            cc  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat + 2) : -1;
            run_div(dop, a, b, lat, cc, $urandom_range(0, 4) == 0 ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
